// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE/REQ/VALID handshake with instruction memory, latches the
// fetched word and computes the next PC. Optional watchdog enabled by FETCH_TIMEOUT_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_data,
    input  logic        imem_ready,
    output logic [31:0] inst_out,
    output logic [5:0]  OPcode,
    output logic [5:0]  Fun,
    output logic        inst_valid,
    input  logic        inst_ack,
    input  logic        Branch,
    input  logic        zero,
    input  logic        Jump,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID, S_ERR} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID} state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        imem_req_q, imem_req_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] next_pc;

    // Targets are relative to the PC of the latched instruction, not the fetch PC.
    assign pc_plus4      = inst_pc_q + 32'd4;
    assign jump_target   = {pc_plus4[31:28], inst_q[25:0], 2'b00};
    assign branch_target = pc_plus4 + {{14{inst_q[15]}}, inst_q[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (Jump) begin
            next_pc = jump_target;
        end else if (Branch && zero) begin
            next_pc = branch_target;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] wdog_q, wdog_d;
    logic [7:0] wdog_inc;
    logic       fetch_err_q, fetch_err_d;

    assign wdog_inc = wdog_q + 8'd1;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
`ifdef FETCH_TIMEOUT_EN
        wdog_d    = wdog_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
`ifdef FETCH_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            S_REQ: begin
                if (imem_ready) begin
                    inst_d    = imem_data;
                    inst_pc_d = pc_q;
                    state_d   = S_VALID;
                end
`ifdef FETCH_TIMEOUT_EN
                else begin
                    wdog_d = wdog_inc;
                    if (wdog_inc == TIMEOUT_LIMIT) begin
                        state_d = S_ERR;
                    end
                end
`endif
            end
            S_VALID: begin
                if (inst_ack) begin
                    pc_d    = next_pc;
                    state_d = S_REQ;
`ifdef FETCH_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                end
            end
`ifdef FETCH_TIMEOUT_EN
            S_ERR: begin
                state_d = S_ERR;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they come straight from flops.
        imem_req_d   = (state_d == S_REQ);
        inst_valid_d = (state_d == S_VALID);
`ifdef FETCH_TIMEOUT_EN
        fetch_err_d  = (state_d == S_ERR);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= RESET_PC;
            imem_req_q   <= 1'b0;
            inst_valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wdog_q       <= '0;
            fetch_err_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            imem_req_q   <= imem_req_d;
            inst_valid_q <= inst_valid_d;
`ifdef FETCH_TIMEOUT_EN
            wdog_q       <= wdog_d;
            fetch_err_q  <= fetch_err_d;
`endif
        end
    end

    assign imem_addr  = pc_q;
    assign imem_req   = imem_req_q;
    assign inst_out   = inst_q;
    assign OPcode     = inst_q[31:26];
    assign Fun        = inst_q[5:0];
    assign inst_valid = inst_valid_q;
    assign pc_out     = inst_pc_q;

`ifdef FETCH_TIMEOUT_EN
    assign fetch_err  = fetch_err_q;
`else
    assign fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised transaction-level bench for instr_fetch against a next-PC reference model.
// Exercises the watchdog path when FETCH_TIMEOUT_EN is defined.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int unsigned TMO    = 6;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic [31:0] inst_out;
    logic [5:0]  OPcode;
    logic [5:0]  Fun;
    logic        inst_valid;
    logic        inst_ack;
    logic        Branch;
    logic        zero;
    logic        Jump;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] m_pc;

    instr_fetch #(
        .RESET_PC       (RST_PC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_data  (imem_data),
        .imem_ready (imem_ready),
        .inst_out   (inst_out),
        .OPcode     (OPcode),
        .Fun        (Fun),
        .inst_valid (inst_valid),
        .inst_ack   (inst_ack),
        .Branch     (Branch),
        .zero       (zero),
        .Jump       (Jump),
        .pc_out     (pc_out),
        .pc_plus4   (pc_plus4),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] inst,
                                             input bit j, input bit b, input bit z);
        logic [31:0] p4;
        int          off;
        p4 = pc + 32'd4;
        if (j) return (p4 & 32'hF000_0000) | ((inst & 32'h03FF_FFFF) * 4);
        if (b && z) begin
            off = int'(inst[15:0]);
            if (off >= 32768) off -= 65536;
            return p4 + 32'(off * 4);
        end
        return p4;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_req",   {31'b0, imem_req},   0);
        check_eq("rst_valid", {31'b0, inst_valid}, 0);
        check_eq("rst_err",   {31'b0, fetch_err},  0);
        check_eq("rst_addr",  imem_addr, RST_PC);
        check_eq("rst_inst",  inst_out, 0);
        imem_ready = 1'b1;
        inst_ack   = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("idle_req",   {31'b0, imem_req},   0);
        check_eq("idle_valid", {31'b0, inst_valid}, 0);
        @(negedge clk);
        m_pc = RST_PC;
    endtask

    // One complete transaction, entered and left at a negedge with the DUT fetching.
    task automatic fetch_one(input logic [31:0] data, input int rdly, input int adly,
                             input bit j, input bit b, input bit z);
        for (int i = 0; i <= rdly; i++) begin
            check_eq("f_req",   {31'b0, imem_req},   1);
            check_eq("f_valid", {31'b0, inst_valid}, 0);
            check_eq("f_err",   {31'b0, fetch_err},  0);
            check_eq("f_addr",  imem_addr, m_pc);
            imem_ready = (i == rdly);
            imem_data  = (i == rdly) ? data : $urandom;
            inst_ack   = 1'($urandom);
            {Jump, Branch, zero} = 3'($urandom);
            @(negedge clk);
        end
        for (int i = 0; i <= adly; i++) begin
            check_eq("v_valid", {31'b0, inst_valid}, 1);
            check_eq("v_req",   {31'b0, imem_req},   0);
            check_eq("v_err",   {31'b0, fetch_err},  0);
            check_eq("v_inst",  inst_out, data);
            check_eq("v_op",    {26'b0, OPcode}, {26'b0, data[31:26]});
            check_eq("v_fun",   {26'b0, Fun},    {26'b0, data[5:0]});
            check_eq("v_pc",    pc_out, m_pc);
            check_eq("v_pc4",   pc_plus4, m_pc + 32'd4);
            imem_ready = 1'($urandom);
            imem_data  = $urandom;
            inst_ack   = (i == adly);
            if (i == adly) {Jump, Branch, zero} = {j, b, z};
            else           {Jump, Branch, zero} = 3'($urandom);
            @(negedge clk);
        end
        m_pc = ref_next(m_pc, data, j, b, z);
    endtask

    task automatic rand_fetches(input int n);
        for (int k = 0; k < n; k++) begin
            fetch_one($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0), 1'($urandom));
        end
    endtask

    initial begin
        rst_n = 1'b1; imem_data = '0; imem_ready = 1'b0; inst_ack = 1'b0;
        Branch = 1'b0; zero = 1'b0; Jump = 1'b0; m_pc = RST_PC;
        #1;
        do_reset();

        check_eq("seq_0", imem_addr, 32'h0);
        fetch_one(32'h0, 0, 0, 0, 0, 0);
        check_eq("seq_4", imem_addr, 32'h4);
        fetch_one(32'h0, 0, 0, 0, 0, 0);
        check_eq("seq_8", imem_addr, 32'h8);
        fetch_one(32'h0800_0040, 0, 0, 1, 0, 0);
        check_eq("jmp_100", imem_addr, 32'h100);
        fetch_one(32'h1000_0003, 0, 0, 0, 1, 1);
        check_eq("br_taken", imem_addr, 32'h110);
        fetch_one(32'h0800_0040, 0, 0, 1, 0, 0);
        fetch_one(32'h1000_0003, 0, 0, 0, 1, 0);
        check_eq("br_not_taken", imem_addr, 32'h104);
        fetch_one(32'h0810_0000, 0, 0, 1, 0, 0);
        check_eq("jmp_far", imem_addr, 32'h0040_0000);
        fetch_one(32'h0800_0040, 0, 0, 1, 1, 1);
        check_eq("jump_wins", imem_addr, 32'h100);
        fetch_one(32'h1000_FFBE, 0, 0, 0, 1, 1);
        check_eq("br_back", imem_addr, 32'hFFFF_FFFC);
        fetch_one($urandom, 0, 0, 0, 0, 0);
        check_eq("wrap", imem_addr, 32'h0);
        fetch_one(32'hDEAD_BEEF, 5, 3, 0, 0, 0);

`ifdef FETCH_TIMEOUT_EN
        imem_ready = 1'b0;
        for (int i = 0; i < int'(TMO); i++) begin
            check_eq("tmo_req", {31'b0, imem_req},  1);
            check_eq("tmo_err", {31'b0, fetch_err}, 0);
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            check_eq("err_set",   {31'b0, fetch_err},  1);
            check_eq("err_req",   {31'b0, imem_req},   0);
            check_eq("err_valid", {31'b0, inst_valid}, 0);
            imem_ready = 1'b1;
            inst_ack   = 1'b1;
            @(negedge clk);
        end
        do_reset();
`else
        fetch_one(32'h1234_5678, 300, 0, 0, 0, 0);
`endif

        rand_fetches(200);

        imem_ready = 1'b0;
        #2;
        do_reset();
        check_eq("post_rst_addr", imem_addr, RST_PC);
        fetch_one(32'h0, 1, 0, 0, 0, 0);
        rand_fetches(50);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
